// File: rtl/process_rx_byte_pkg.sv
`default_nettype none
// ============================================================================
// Module      : process_rx_byte_pkg
// Description : Shared definitions for the receive side of the USB serial
//               interface engine. Holds the line-state codes and the control
//               codes that travel with every byte/packet event to the packet
//               receiver, plus a small event record and helpers.
// Contents    : SE0, SE1                     - fixed line-state codes
//               DATA_START .. DATA_ALIGN_ERROR - event control codes
//               rx_event_t                   - {data byte, control code}
//               is_jk(), make_event()        - helpers
// Revision    : 1.0 - initial release
// ============================================================================
package process_rx_byte_pkg;

  // Line states that are neither J nor K, independent of bus speed.
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] SE1 = 2'b11;

  // Event control codes seen by the packet receiver. The two error codes are
  // distinct so the receiver can tell a broken stuff run from a truncated byte.
  localparam logic [7:0] DATA_START           = 8'h01;
  localparam logic [7:0] DATA_STREAM          = 8'h02;
  localparam logic [7:0] DATA_STOP            = 8'h03;
  localparam logic [7:0] DATA_BIT_STUFF_ERROR = 8'h04;
  localparam logic [7:0] DATA_ALIGN_ERROR     = 8'h05;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] ctrl;
  } rx_event_t;

  // A sampled state carries a data bit only when it is a J or a K.
  function automatic logic is_jk(input logic [1:0] state);
    return (state != SE0) && (state != SE1);
  endfunction

  function automatic rx_event_t make_event(input logic [7:0] data,
                                           input logic [7:0] ctrl);
    rx_event_t ev;
    ev.data = data;
    ev.ctrl = ctrl;
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/process_rx_byte_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
// Module      : process_rx_byte_nrzi_unstuff
// Description : NRZI decoder and consecutive-ones counter for the RX byte
//               processor. Classifies each bit strobe and flags the stuffed
//               bit position; the parent FSM does SYNC matching, byte
//               assembly and event emission.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               j_bit         - line-state code for J
//               line_state    - sampled line state
//               bit_en        - line_state valid this cycle
//               ref_j         - decode against J instead of the last state
//               count_en      - ones counting active (DATA/STUFF)
//               jk            - strobe carrying a J or K
//               bit_valid     - strobe carrying a data bit (not a stuff bit)
//               bit_val       - decoded bit value
//               stuff_req     - this data bit completes a run of MAX_ONES
//               stuff_err     - stuff position decoded as 1
//               se0, se1      - strobe carrying SE0 / SE1
// Revision    : 1.0 - initial release
// ============================================================================
module process_rx_byte_nrzi_unstuff
  import process_rx_byte_pkg::*;
#(
  parameter int MAX_ONES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] j_bit,
  input  logic [1:0] line_state,
  input  logic       bit_en,
  input  logic       ref_j,
  input  logic       count_en,
  output logic       jk,
  output logic       bit_valid,
  output logic       bit_val,
  output logic       stuff_req,
  output logic       stuff_err,
  output logic       se0,
  output logic       se1
);

  localparam logic [2:0] ONES_MAX = 3'(MAX_ONES);

  logic [1:0] last_state;
  logic [2:0] one_cnt;
  logic       in_stuff;

  always_comb begin
    jk        = bit_en && is_jk(line_state);
    se0       = bit_en && (line_state == SE0);
    se1       = bit_en && (line_state == SE1);
    // Unchanged line state decodes as 1, a transition as 0.
    bit_val   = (line_state == (ref_j ? j_bit : last_state));
    // Once the run is full, the next J/K is the stuffed bit, not data.
    in_stuff  = count_en && (one_cnt == ONES_MAX);
    bit_valid = jk && !in_stuff;
    stuff_err = jk && in_stuff && bit_val;
    stuff_req = bit_valid && count_en && bit_val && (one_cnt == (ONES_MAX - 3'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_state <= SE0;
      one_cnt    <= '0;
    end else begin
      if (jk) begin
        last_state <= line_state;
      end
      if (!count_en) begin
        one_cnt <= '0;
      end else if (jk) begin
        if (in_stuff || !bit_val) begin
          one_cnt <= '0;
        end else if (one_cnt != ONES_MAX) begin
          one_cnt <= one_cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/process_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : process_rx_byte
// Description : Receive-side byte processor of the USB serial interface
//               engine. Detects SYNC, NRZI-decodes, removes stuffed bits,
//               assembles LSB-first bytes and detects EOP. Every byte or
//               packet event is a one-cycle strobe with a control code.
// Ports       : clk           in  1  clock
//               rst           in  1  synchronous active-high reset
//               JBit          in  2  line-state code for J
//               KBit          in  2  line-state code for K
//               RxBitStateIn  in  2  sampled line state
//               RxBitWEn      in  1  RxBitStateIn valid strobe
//               RxByteOut     out 8  received byte (8'h00 on STOP/error)
//               RxCtrlOut     out 8  event control code
//               RxByteWEn     out 1  event strobe
//               rxActive      out 1  packet in progress
// Revision    : 1.0 - initial release
// ============================================================================
module process_rx_byte
  import process_rx_byte_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         MAX_ONES     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] JBit,
  input  logic [1:0] KBit,
  input  logic [1:0] RxBitStateIn,
  input  logic       RxBitWEn,
  output logic [7:0] RxByteOut,
  output logic [7:0] RxCtrlOut,
  output logic       RxByteWEn,
  output logic       rxActive
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    STUFF  = 3'd3,
    WAIT_J = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       first_byte, first_byte_nxt;
  logic       active_q, active_nxt;
  rx_event_t  event_q, event_nxt;
  logic       wen_q, wen_nxt;

  logic       jk, bit_valid, bit_val, stuff_req, stuff_err, se0, se1;
  logic [7:0] shifted;

  process_rx_byte_nrzi_unstuff #(
    .MAX_ONES (MAX_ONES)
  ) u_nrzi_unstuff (
    .clk        (clk),
    .rst        (rst),
    .j_bit      (JBit),
    .line_state (RxBitStateIn),
    .bit_en     (RxBitWEn),
    .ref_j      (state == IDLE),
    .count_en   ((state == DATA) || (state == STUFF)),
    .jk         (jk),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .stuff_req  (stuff_req),
    .stuff_err  (stuff_err),
    .se0        (se0),
    .se1        (se1)
  );

  // First bit received lands in bit 7 and ends up in bit 0 after eight shifts.
  assign shifted = {bit_val, shift_q[7:1]};

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_q;
    bit_cnt_nxt    = bit_cnt;
    first_byte_nxt = first_byte;
    active_nxt     = active_q;
    event_nxt      = event_q;
    wen_nxt        = 1'b0;

    case (state)
      IDLE: begin
        // The first K after idle J is the first SYNC bit and decodes as 0.
        if (jk && (RxBitStateIn == KBit)) begin
          shift_nxt   = {bit_val, 7'd0};
          bit_cnt_nxt = 3'd1;
          state_nxt   = SYNC;
        end
      end

      SYNC: begin
        if (se0 || se1) begin
          bit_cnt_nxt = 3'd0;
          state_nxt   = WAIT_J;
        end else if (bit_valid) begin
          shift_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shifted == SYNC_PATTERN) begin
              active_nxt     = 1'b1;
              first_byte_nxt = 1'b1;
              state_nxt      = DATA;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end

      DATA, STUFF: begin
        if (se0) begin
          // EOP is only clean on a byte boundary; otherwise the partial
          // byte is dropped and reported as misaligned.
          event_nxt   = make_event(8'h00, (bit_cnt == 3'd0) ? DATA_STOP : DATA_ALIGN_ERROR);
          wen_nxt     = 1'b1;
          bit_cnt_nxt = 3'd0;
          state_nxt   = WAIT_J;
        end else if (se1 || stuff_err) begin
          event_nxt   = make_event(8'h00, DATA_BIT_STUFF_ERROR);
          wen_nxt     = 1'b1;
          bit_cnt_nxt = 3'd0;
          state_nxt   = WAIT_J;
        end else if (state == STUFF) begin
          // A valid stuffed 0 is dropped without touching the bit count.
          if (jk) begin
            state_nxt = DATA;
          end
        end else if (bit_valid) begin
          shift_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            event_nxt      = make_event(shifted, first_byte ? DATA_START : DATA_STREAM);
            wen_nxt        = 1'b1;
            first_byte_nxt = 1'b0;
          end
          // The byte completing on this bit is still emitted above.
          if (stuff_req) begin
            state_nxt = STUFF;
          end
        end
      end

      WAIT_J: begin
        // Trailing SE0s and stray K bits are ignored until the bus returns to J.
        if (jk && (RxBitStateIn == JBit)) begin
          active_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      first_byte <= 1'b0;
      active_q   <= 1'b0;
      event_q    <= '0;
      wen_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      first_byte <= first_byte_nxt;
      active_q   <= active_nxt;
      event_q    <= event_nxt;
      wen_q      <= wen_nxt;
    end
  end

  assign RxByteOut = event_q.data;
  assign RxCtrlOut = event_q.ctrl;
  assign RxByteWEn = wen_q;
  assign rxActive  = active_q;

endmodule
`default_nettype wire

// File: tb/tb_process_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_process_rx_byte
// Description : Self-checking bench for process_rx_byte. Builds NRZI line
//               traffic with bit stuffing, queues the expected events, and
//               compares them against the events the DUT strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_process_rx_byte;
  import process_rx_byte_pkg::*;

  localparam logic [1:0] J_CODE = 2'b10;
  localparam logic [1:0] K_CODE = 2'b01;

  logic       clk;
  logic       rst;
  logic [1:0] j_code;
  logic [1:0] k_code;
  logic [1:0] line;
  logic       bit_wen;
  logic [7:0] rx_byte;
  logic [7:0] rx_ctrl;
  logic       rx_wen;
  logic       rx_active;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  logic [1:0] lvl;
  int         ones;

  process_rx_byte dut (
    .clk          (clk),
    .rst          (rst),
    .JBit         (j_code),
    .KBit         (k_code),
    .RxBitStateIn (line),
    .RxBitWEn     (bit_wen),
    .RxByteOut    (rx_byte),
    .RxCtrlOut    (rx_ctrl),
    .RxByteWEn    (rx_wen),
    .rxActive     (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every event the DUT produces.
  always @(negedge clk) begin
    if (rx_wen === 1'b1) got_q.push_back({rx_byte, rx_ctrl});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_state(input logic [1:0] s);
    @(negedge clk);
    line    = s;
    bit_wen = 1'b1;
    @(negedge clk);
    bit_wen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_nrzi(input logic b);
    if (!b) lvl = (lvl == J_CODE) ? K_CODE : J_CODE;
    drive_state(lvl);
  endtask

  task automatic send_data_bit(input logic b);
    send_nrzi(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_nrzi(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic send_idle(input int n);
    lvl = J_CODE;
    for (int i = 0; i < n; i++) drive_state(J_CODE);
  endtask

  // K J K J K J K K from idle J: seven transitions then one repeat.
  task automatic send_sync();
    lvl = J_CODE;
    for (int i = 0; i < 7; i++) send_nrzi(1'b0);
    send_nrzi(1'b1);
    ones = 0;
  endtask

  task automatic send_eop();
    drive_state(SE0);
    drive_state(SE0);
    drive_state(J_CODE);
    lvl  = J_CODE;
    ones = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_wen !== 1'b0)   begin errors++; $display("FAIL reset_wen: got %b, expected 0", rx_wen); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h, expected 00", rx_byte); end
    checks++; if (rx_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h, expected 00", rx_ctrl); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b, expected 0", rx_active); end
    rst = 1'b0;
    send_idle(3);
  endtask

  task automatic test_basic();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL basic_active_sync: got %b, expected 1", rx_active); end
    exp_q.push_back({8'hA5, DATA_START});
    send_byte(8'hA5);
    exp_q.push_back({8'h00, DATA_STOP});
    drive_state(SE0);
    drive_state(SE0);
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL basic_active_eop: got %b, expected 1", rx_active); end
    drive_state(J_CODE);
    lvl = J_CODE; ones = 0;
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL basic_active_j: got %b, expected 0", rx_active); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL basic_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stuffing();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'hFF, DATA_START});
    send_byte(8'hFF);
    exp_q.push_back({8'hFF, DATA_STREAM});
    send_byte(8'hFF);
    exp_q.push_back({8'h00, DATA_STOP});
    send_eop();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stuff_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL stuff_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stuff_error();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h00, DATA_BIT_STUFF_ERROR});
    for (int i = 0; i < 7; i++) drive_state(lvl);
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL stufferr_active_wait: got %b, expected 1", rx_active); end
    drive_state(J_CODE);
    lvl = J_CODE; ones = 0;
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL stufferr_active_idle: got %b, expected 0", rx_active); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stufferr_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL stufferr_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_align();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h3C, DATA_START});
    send_byte(8'h3C);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    exp_q.push_back({8'h00, DATA_ALIGN_ERROR});
    send_eop();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL align_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL align_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_bad_sync();
    logic [15:0] e, g;
    logic [1:0]  bad [8];
    bad = '{K_CODE, J_CODE, J_CODE, K_CODE, J_CODE, K_CODE, K_CODE, K_CODE};
    send_idle(2);
    for (int i = 0; i < 8; i++) drive_state(bad[i]);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL badsync_events: got %0d events, expected 0", got_q.size()); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL badsync_active: got %b, expected 0", rx_active); end
    got_q.delete();
    send_idle(3);
    send_sync();
    exp_q.push_back({8'h5A, DATA_START});
    send_byte(8'h5A);
    exp_q.push_back({8'h00, DATA_STOP});
    send_eop();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL badsync_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL badsync_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_empty_packet();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h00, DATA_STOP});
    send_eop();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL empty_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL empty_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_se1();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h0F, DATA_START});
    send_byte(8'h0F);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    exp_q.push_back({8'h00, DATA_BIT_STUFF_ERROR});
    drive_state(SE1);
    drive_state(J_CODE);
    lvl = J_CODE; ones = 0;
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL se1_active: got %b, expected 0", rx_active); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL se1_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL se1_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, g;
    logic [7:0]  d;
    for (int p = 0; p < 3; p++) begin
      send_idle(2);
      send_sync();
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back({d, (i == 0) ? DATA_START : DATA_STREAM});
        send_byte(d);
      end
      exp_q.push_back({8'h00, DATA_STOP});
      send_eop();
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e, g;
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h11, DATA_START});
    send_byte(8'h11);
    exp_q.push_back({8'h00, DATA_STOP});
    send_eop();
    send_idle(2);
    send_sync();
    exp_q.push_back({8'h22, DATA_START});
    send_byte(8'h22);
    for (int i = 0; i < 4; i++) send_data_bit(i[0]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rx_wen !== 1'b0)    begin errors++; $display("FAIL rstmid_wen: got %b, expected 0", rx_wen); end
    checks++; if (rx_byte !== 8'h00)  begin errors++; $display("FAIL rstmid_byte: got %h, expected 00", rx_byte); end
    checks++; if (rx_ctrl !== 8'h00)  begin errors++; $display("FAIL rstmid_ctrl: got %h, expected 00", rx_ctrl); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL rstmid_active: got %b, expected 0", rx_active); end
    rst = 1'b0;
    send_idle(3);
    send_sync();
    exp_q.push_back({8'h44, DATA_START});
    send_byte(8'h44);
    exp_q.push_back({8'h00, DATA_STOP});
    send_eop();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d events, expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rstmid_event: got byte %h ctrl %h, expected byte %h ctrl %h", g[15:8], g[7:0], e[15:8], e[7:0]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    j_code  = J_CODE;
    k_code  = K_CODE;
    line    = J_CODE;
    bit_wen = 1'b0;
    lvl     = J_CODE;
    ones    = 0;
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_align();
    test_bad_sync();
    test_empty_packet();
    test_se1();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
